// File: rtl/memory_access_unit.sv
// Memory access unit between the RV32I core and a single word-wide synchronous RAM.
// Decodes the bank, checks faults, extends sub-word loads and does read-modify-write for sub-word stores.
module memory_access_unit #(
    parameter logic [3:0] INST_BANK     = 4'h0,
    parameter logic [3:0] DATA_BANK     = 4'h1,
    parameter int         ADDR_W        = 10,
    parameter bit         INST_WRITABLE = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [31:0]       req_addr,
    input  logic              req_wr,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [31:0]       req_wr_data,
    output logic              done,
    output logic [31:0]       rd_data,
    output logic [3:0]        exception,
    output logic [ADDR_W:0]   ram_addr,
    input  logic [31:0]       ram_rd_data,
    output logic [31:0]       ram_wr_data,
    output logic              ram_wr_ena
);

    // state  | meaning
    // IDLE   | ready; accepts a request, issues word stores directly
    // READ   | RAM word valid; extract load data or write merged sub-word store
    // FAULT  | faulting request completes (done) with mask already registered
    // FINISH | successful request completes (done)
    typedef enum logic [1:0] {IDLE, READ, FAULT, FINISH} state_t;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;
    localparam logic [1:0] SZ_RSVD = 2'd3;

    state_t state, state_nxt;

    logic [ADDR_W:0] word_q;
    logic [1:0]      off_q;
    logic [1:0]      size_q;
    logic            wr_q;
    logic            uns_q;
    logic [31:0]     wdata_q;

    logic            accept;
    logic [3:0]      req_bank;
    logic [3:0]      exc_mask;
    logic [ADDR_W:0] req_word;
    logic            word_store;
    logic [31:0]     load_val;
    logic [31:0]     merged;
    logic [7:0]      byte_v;
    logic [15:0]     half_v;
    logic            unused_addr_bits;

    assign unused_addr_bits = ^req_addr[27:ADDR_W+2];

    assign accept     = req_valid && (state == IDLE);
    assign req_bank   = req_addr[31:28];
    assign req_word   = {req_bank == DATA_BANK, req_addr[ADDR_W+1:2]};
    assign word_store = req_wr && (req_size == SZ_WORD);

    always_comb begin
        exc_mask    = 4'b0000;
        exc_mask[0] = ((req_size == SZ_HALF) && req_addr[0]) ||
                      ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00));
        exc_mask[1] = (req_bank != INST_BANK) && (req_bank != DATA_BANK);
        exc_mask[2] = req_wr && (req_bank == INST_BANK) && !INST_WRITABLE;
        exc_mask[3] = (req_size == SZ_RSVD);
    end

    // Lane selection from the latched byte offset
    assign byte_v = ram_rd_data[{off_q, 3'b000} +: 8];
    assign half_v = ram_rd_data[{off_q[1], 4'b0000} +: 16];

    always_comb begin
        load_val = ram_rd_data;
        case (size_q)
            SZ_BYTE: load_val = {{24{byte_v[7] & ~uns_q}}, byte_v};
            SZ_HALF: load_val = {{16{half_v[15] & ~uns_q}}, half_v};
            default: load_val = ram_rd_data;
        endcase
    end

    always_comb begin
        merged = ram_rd_data;
        if (size_q == SZ_BYTE)
            merged[{off_q, 3'b000} +: 8] = wdata_q[7:0];
        else
            merged[{off_q[1], 4'b0000} +: 16] = wdata_q[15:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            rd_data   <= 32'd0;
            exception <= 4'd0;
            word_q    <= '0;
            off_q     <= 2'd0;
            size_q    <= 2'd0;
            wr_q      <= 1'b0;
            uns_q     <= 1'b0;
            wdata_q   <= 32'd0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                word_q  <= req_word;
                off_q   <= req_addr[1:0];
                size_q  <= req_size;
                wr_q    <= req_wr;
                uns_q   <= req_unsigned;
                wdata_q <= req_wr_data;
                // Fault results must be visible in the FAULT (done) cycle
                if (|exc_mask) begin
                    rd_data   <= 32'd0;
                    exception <= exc_mask;
                end else if (word_store) begin
                    exception <= 4'd0;
                end
            end
            if (state == READ) begin
                exception <= 4'd0;
                if (!wr_q)
                    rd_data <= load_val;
            end
        end
    end

    always_comb begin
        state_nxt   = state;
        req_ready   = 1'b0;
        done        = 1'b0;
        ram_addr    = '0;
        ram_wr_data = 32'd0;
        ram_wr_ena  = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                ram_addr  = req_word;
                if (accept) begin
                    if (|exc_mask) begin
                        state_nxt = FAULT;
                    end else if (word_store) begin
                        ram_wr_ena  = 1'b1;
                        ram_wr_data = req_wr_data;
                        state_nxt   = FINISH;
                    end else begin
                        state_nxt = READ;
                    end
                end
            end
            READ: begin
                ram_addr = word_q;
                if (wr_q) begin
                    ram_wr_ena  = 1'b1;
                    ram_wr_data = merged;
                end
                state_nxt = FINISH;
            end
            FAULT: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            FINISH: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        // A synchronous reset aborts the operation in its own cycle
        if (rst) begin
            done        = 1'b0;
            ram_addr    = '0;
            ram_wr_data = 32'd0;
            ram_wr_ena  = 1'b0;
        end
    end

endmodule

// File: tb/tb_memory_access_unit.sv
// Directed bench for memory_access_unit with a behavioural synchronous RAM.
module tb_memory_access_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        req_wr;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_wr_data;
    logic        done;
    logic [31:0] rd_data;
    logic [3:0]  exception;
    logic [10:0] ram_addr;
    logic [31:0] ram_rd_data;
    logic [31:0] ram_wr_data;
    logic        ram_wr_ena;

    logic [31:0] mem [0:2047];

    int n_cmp = 0;
    int n_err = 0;

    int          lat;
    int          wr_cnt;
    logic [31:0] wa;
    int          cyc, acc1, acc2, done1, rdy_bad, wcount, dcount;

    memory_access_unit dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_wr(req_wr), .req_size(req_size),
        .req_unsigned(req_unsigned), .req_wr_data(req_wr_data), .done(done),
        .rd_data(rd_data), .exception(exception), .ram_addr(ram_addr),
        .ram_rd_data(ram_rd_data), .ram_wr_data(ram_wr_data), .ram_wr_ena(ram_wr_ena)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_wr_ena) mem[ram_addr] <= ram_wr_data;
        ram_rd_data <= mem[ram_addr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One request; lat counts cycles from the accept cycle (1) through the done cycle.
    task automatic run(input logic [31:0] a, input logic w, input logic [1:0] s,
                       input logic u, input logic [31:0] d,
                       output int l, output int wc, output logic [31:0] wad);
        @(negedge clk);
        req_valid = 1'b1; req_addr = a; req_wr = w; req_size = s;
        req_unsigned = u; req_wr_data = d;
        #1;
        l = 1; wc = 0; wad = 32'hffff_ffff;
        if (ram_wr_ena) begin wc++; wad = 32'(ram_addr); end
        @(posedge clk);
        #1 req_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            l++;
            if (ram_wr_ena) begin wc++; wad = 32'(ram_addr); end
            if (done) break;
            if (i == 9) l = 99;
        end
    endtask

    initial begin
        for (int i = 0; i < 2048; i++) mem[i] = 32'd0;
        rst = 1'b1; req_valid = 1'b0; req_addr = 32'd0; req_wr = 1'b0;
        req_size = 2'd0; req_unsigned = 1'b0; req_wr_data = 32'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", 32'(req_ready), 32'd1);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_rd_data", rd_data, 32'd0);
        chk("rst_exception", 32'(exception), 32'd0);
        chk("rst_wr_ena", 32'(ram_wr_ena), 32'd0);
        chk("rst_ram_addr", 32'(ram_addr), 32'd0);
        chk("rst_ram_wr_data", ram_wr_data, 32'd0);
        rst = 1'b0;

        // Word store then word load
        run(32'h1000_0010, 1'b1, 2'd2, 1'b0, 32'hDEAD_BEEF, lat, wr_cnt, wa);
        chk("sw_latency", 32'(lat), 32'd2);
        chk("sw_wr_count", 32'(wr_cnt), 32'd1);
        chk("sw_wr_addr", wa, 32'h404);
        chk("sw_exception", 32'(exception), 32'd0);
        @(negedge clk);
        chk("sw_mem", mem[11'h404], 32'hDEAD_BEEF);
        run(32'h1000_0010, 1'b0, 2'd2, 1'b0, 32'd0, lat, wr_cnt, wa);
        chk("lw_latency", 32'(lat), 32'd3);
        chk("lw_rd_data", rd_data, 32'hDEAD_BEEF);
        chk("lw_exception", 32'(exception), 32'd0);
        chk("lw_wr_count", 32'(wr_cnt), 32'd0);

        // Byte store read-modify-write
        mem[11'h404] = 32'h1122_3344;
        run(32'h1000_0013, 1'b1, 2'd0, 1'b0, 32'h0000_005A, lat, wr_cnt, wa);
        chk("sb_latency", 32'(lat), 32'd3);
        chk("sb_wr_count", 32'(wr_cnt), 32'd1);
        chk("sb_rd_data_kept", rd_data, 32'hDEAD_BEEF);
        @(negedge clk);
        chk("sb_mem", mem[11'h404], 32'h5A22_3344);
        run(32'h1000_0013, 1'b0, 2'd0, 1'b0, 32'd0, lat, wr_cnt, wa);
        chk("lb_5a", rd_data, 32'h0000_005A);
        mem[11'h404] = 32'h8022_3344;
        run(32'h1000_0013, 1'b0, 2'd0, 1'b0, 32'd0, lat, wr_cnt, wa);
        chk("lb_80_signed", rd_data, 32'hFFFF_FF80);
        run(32'h1000_0013, 1'b0, 2'd0, 1'b1, 32'd0, lat, wr_cnt, wa);
        chk("lbu_80", rd_data, 32'h0000_0080);

        // Half loads of the upper half
        mem[11'h400] = 32'hBEEF_1234;
        run(32'h1000_0002, 1'b0, 2'd1, 1'b0, 32'd0, lat, wr_cnt, wa);
        chk("lh_signed", rd_data, 32'hFFFF_BEEF);
        chk("lh_latency", 32'(lat), 32'd3);
        run(32'h1000_0002, 1'b0, 2'd1, 1'b1, 32'd0, lat, wr_cnt, wa);
        chk("lhu", rd_data, 32'h0000_BEEF);

        // Faults
        run(32'h1000_0002, 1'b0, 2'd2, 1'b0, 32'd0, lat, wr_cnt, wa);
        chk("f_misalign_exc", 32'(exception), 32'h1);
        chk("f_misalign_lat", 32'(lat), 32'd2);
        chk("f_misalign_rd", rd_data, 32'd0);
        run(32'h3000_0000, 1'b0, 2'd2, 1'b0, 32'd0, lat, wr_cnt, wa);
        chk("f_unmapped_exc", 32'(exception), 32'h2);
        chk("f_unmapped_lat", 32'(lat), 32'd2);
        run(32'h0000_0000, 1'b1, 2'd2, 1'b0, 32'hCAFE_F00D, lat, wr_cnt, wa);
        chk("f_protect_exc", 32'(exception), 32'h4);
        chk("f_protect_lat", 32'(lat), 32'd2);
        chk("f_protect_wr", 32'(wr_cnt), 32'd0);
        chk("f_protect_rd", rd_data, 32'd0);
        @(negedge clk);
        chk("f_protect_mem", mem[11'h000], 32'd0);
        run(32'h1000_0000, 1'b0, 2'd3, 1'b0, 32'd0, lat, wr_cnt, wa);
        chk("f_rsvd_exc", 32'(exception), 32'h8);
        chk("f_rsvd_lat", 32'(lat), 32'd2);
        chk("f_rsvd_wr", 32'(wr_cnt), 32'd0);
        run(32'h1000_0000, 1'b0, 2'd2, 1'b0, 32'd0, lat, wr_cnt, wa);
        chk("exc_cleared", 32'(exception), 32'd0);
        chk("lw_bank1_word0", rd_data, 32'hBEEF_1234);

        // Reset during READ of a byte store
        mem[11'h404] = 32'h1122_3344;
        @(negedge clk);
        req_valid = 1'b1; req_addr = 32'h1000_0012; req_wr = 1'b1;
        req_size = 2'd0; req_wr_data = 32'h77;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst_read_wr_ena", 32'(ram_wr_ena), 32'd0);
        @(negedge clk);
        chk("rst_read_ready", 32'(req_ready), 32'd1);
        chk("rst_read_done", 32'(done), 32'd0);
        rst = 1'b0;
        wcount = 0; dcount = 0;
        repeat (4) begin
            @(negedge clk);
            if (ram_wr_ena) wcount++;
            if (done) dcount++;
        end
        chk("rst_read_no_wr", 32'(wcount), 32'd0);
        chk("rst_read_no_done", 32'(dcount), 32'd0);
        chk("rst_read_mem", mem[11'h404], 32'h1122_3344);

        // Back-to-back with req_valid held high
        @(negedge clk);
        req_valid = 1'b1; req_addr = 32'h1000_0010; req_wr = 1'b0;
        req_size = 2'd2; req_unsigned = 1'b0;
        cyc = 0; acc1 = -1; acc2 = -1; done1 = -1; rdy_bad = 0;
        for (int i = 0; i < 12; i++) begin
            #1;
            if (done && done1 < 0) done1 = cyc;
            if (acc1 >= 0 && done1 < 0 && req_ready) rdy_bad++;
            if (req_valid && req_ready) begin
                if (acc1 < 0) acc1 = cyc;
                else if (acc2 < 0) acc2 = cyc;
            end
            if (acc2 >= 0) break;
            @(negedge clk);
            cyc++;
        end
        req_valid = 1'b0;
        chk("b2b_first_accept", 32'(acc1), 32'd0);
        chk("b2b_first_done", 32'(done1), 32'd2);
        chk("b2b_second_accept", 32'(acc2), 32'd3);
        chk("b2b_ready_low", 32'(rdy_bad), 32'd0);
        repeat (4) @(negedge clk);
        chk("b2b_rd_data", rd_data, 32'h1122_3344);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
